csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning CSR data width; legal values are 32 and 64.
REQ-002 Parameter MTVEC_RESET, default 0, meaning the reset value of mtvec.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 req_valid  in  1  CSR instruction request present.
REQ-006 req_ready  out  1  unit can accept a request.
REQ-007 req_func3  in  3  instruction funct3: bit2 = immediate form; [1:0] 01 = RW, 10 = RS, 11 = RC.
REQ-008 req_addr  in  12  CSR address.
REQ-009 req_rs1_idx  in  5  rs1 index; this is the uimm field when func3[2]=1.
REQ-010 req_rs1_data  in  XLEN  rs1 register value.
REQ-011 instret_pulse  in  1  one instruction retired this cycle.
REQ-012 resp_valid  out  1  one-cycle response strobe.
REQ-013 resp_rdata  out  XLEN  old CSR value, destined for rd.
REQ-014 resp_illegal  out  1  illegal-instruction flag, qualified by resp_valid.

Function
REQ-015 The unit SHALL run a three-state FSM: IDLE -> EXEC -> RESP -> IDLE.
REQ-016 In IDLE, req_ready=1; the handshake req_valid&&req_ready SHALL capture func3, addr, rs1_idx and rs1_data, and the state SHALL go to EXEC.
REQ-017 In EXEC and RESP, req_ready=0; EXEC SHALL always advance to RESP, and RESP SHALL always advance to IDLE.
REQ-018 Operand selection: operand = zero-extended uimm when func3[2]=1, otherwise rs1_data.
REQ-019 New value: RW -> operand; RS -> old | operand; RC -> old & ~operand.
REQ-020 Write-enable: RW always writes; RS/RC write only when rs1_idx != 0.
REQ-021 The CSR write SHALL commit on the EXEC->RESP edge.
REQ-022 RESP SHALL drive resp_valid=1, resp_rdata=old value, and resp_illegal; this gives a response 2 cycles after acceptance and one request per 3 cycles.
REQ-023 Illegal conditions SHALL be any of: unknown address; func3[1:0]=00; or addr[11:10]=11 with write-enable set.
REQ-024 On an illegal request there SHALL be no write, and resp_rdata SHALL be 0.
REQ-025 Implemented CSRs: mscratch 0x340, mtvec 0x305, mepc 0x341, mcause 0x342.
REQ-026 mtvec[1:0] and mepc[1:0] SHALL read as 0 and ignore writes.
REQ-027 Counters: mcycle 0xB00 and minstret 0xB02 are 64-bit. mcycle increments every cycle; minstret increments when instret_pulse=1. Both wrap from all-ones to 0.
REQ-028 When XLEN=32, the upper counter halves SHALL be mcycleh 0xB80 and minstreth 0x82 offset, i.e. address 0xB82. When XLEN=64, 0xB80 and 0xB82 SHALL be illegal.
REQ-029 Read-only mirrors: cycle 0xC00 and instret 0xC02 (plus 0xC80/0xC82 when XLEN=32) SHALL return the counter value.
REQ-030 A CSR write to a counter half SHALL override that cycle's increment of that half; the other half increments normally, without carry from the written half.
REQ-031 When XLEN=32, the carry from the low 32 bits into the high half SHALL occur on the same edge as the increment.

Reset
REQ-032 While reset=1, req_ready=0 and resp_valid=0.
REQ-033 The FSM SHALL reset to IDLE, and resp_rdata and resp_illegal SHALL reset to 0.
REQ-034 All CSRs SHALL reset to 0 except mtvec, which resets to MTVEC_RESET with bits [1:0] forced to 0.
REQ-035 Reset asserted in EXEC or RESP SHALL abort the operation: no CSR write and no response.

Configuration
REQ-036 Macro CSR_COUNTERS_EN: when defined, the counters and their mirrors SHALL exist as specified.
REQ-037 When CSR_COUNTERS_EN is undefined, all counter and mirror addresses SHALL be illegal, there SHALL be no counter flops, and instret_pulse SHALL be ignored.

Verification
REQ-038 Swap: with mscratch=0x0, issue csrrw 0x340 with rs1=5, data 0xDEADBEEF -> resp 2 cycles later with rdata 0x0 and illegal 0; a subsequent read returns 0xDEADBEEF.
REQ-039 Set/clear: with mscratch=0xF0, csrrsi uimm=0x3 -> rdata 0xF0 and mscratch 0xF3; then csrrc with rs1=0 -> rdata 0xF3 and no write.
REQ-040 Read-only: csrrw to 0xC00 -> illegal 1, rdata 0, counters undisturbed; csrrs 0xC00 with rs1=0 -> illegal 0, rdata equals the cycle count.
REQ-041 Counter carry (XLEN=32): write mcycle=0xFFFFFFFF -> the next cycle reads mcycle low=0x0 and mcycleh incremented by 1; write minstreth while instret_pulse=1 -> the written value is kept.
REQ-042 Reset and handshake: assert reset during EXEC of csrrw mscratch -> no resp_valid, mscratch=0, req_ready=1 one cycle after reset deasserts; req_valid held in EXEC/RESP is not accepted.
REQ-043 Build without CSR_COUNTERS_EN: csrrs 0xB00 with rs1=0 -> illegal 1.

Source files
------------

// File: rtl/csr_unit_if.sv
// csr_unit_if -- request/response bundle for the CSR unit.
//   req_valid/req_ready   : request handshake (master -> slave / slave -> master)
//   req_func3, req_addr   : instruction funct3 and CSR address
//   req_rs1_idx           : rs1 index, doubles as uimm for the immediate forms
//   req_rs1_data          : rs1 register value
//   resp_valid            : one-cycle response strobe
//   resp_rdata            : old CSR value (0 when illegal)
//   resp_illegal          : illegal-instruction flag, qualified by resp_valid
interface csr_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_func3;
  logic [11:0]     req_addr;
  logic [4:0]      req_rs1_idx;
  logic [XLEN-1:0] req_rs1_data;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  modport master (
    output req_valid, req_func3, req_addr, req_rs1_idx, req_rs1_data,
    input  req_ready, resp_valid, resp_rdata, resp_illegal
  );

  modport slave (
    input  req_valid, req_func3, req_addr, req_rs1_idx, req_rs1_data,
    output req_ready, resp_valid, resp_rdata, resp_illegal
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit -- machine-mode CSR execution unit (csrrw/csrrs/csrrc and immediate forms).
// Three-state FSM IDLE -> EXEC -> RESP: a request is accepted in IDLE, the CSR
// write commits on the EXEC->RESP edge and the response strobe is driven in RESP.
// Ports:
//   clk           : clock, all state updates on the rising edge
//   reset         : synchronous, active-high
//   instret_pulse : one instruction retired this cycle (counts minstret)
//   bus           : csr_unit_if.slave request/response bundle
// Build option: define CSR_COUNTERS_EN to include mcycle/minstret (0xB00/0xB02,
// upper halves 0xB80/0xB82 when XLEN=32) and the read-only mirrors 0xC00/0xC02
// (0xC80/0xC82 when XLEN=32). Without it those addresses are illegal and
// instret_pulse is ignored.
module csr_unit #(
  parameter int unsigned    XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instret_pulse,
  csr_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e          state_q;
  logic            ready_q, resp_valid_q, illegal_q;
  logic [XLEN-1:0] rdata_q;
  logic [2:0]      func3_q;
  logic [11:0]     addr_q;
  logic [4:0]      idx_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] mscratch_q, mtvec_q, mepc_q, mcause_q;

  logic [XLEN-1:0] operand, rd_val, new_val;
  logic            known, wen, illegal, do_write;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
  logic unused_instret;
  assign unused_instret = instret_pulse;
`endif

  assign bus.req_ready    = ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_illegal = illegal_q;

  // Decode and compute the read-modify-write result for the captured request.
  always_comb begin
    operand = func3_q[2] ? {{(XLEN-5){1'b0}}, idx_q} : data_q;
    wen     = (func3_q[1:0] == 2'b01) || (idx_q != '0);
    known   = 1'b1;
    rd_val  = '0;
    unique case (addr_q)
      12'h340: rd_val = mscratch_q;
      12'h305: rd_val = mtvec_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: rd_val = mcycle_q[XLEN-1:0];
      12'hB02, 12'hC02: rd_val = minstret_q[XLEN-1:0];
      12'hB80, 12'hC80: begin
        known  = (XLEN == 32);
        rd_val = (XLEN == 32) ? XLEN'(mcycle_q[63:32]) : '0;
      end
      12'hB82, 12'hC82: begin
        known  = (XLEN == 32);
        rd_val = (XLEN == 32) ? XLEN'(minstret_q[63:32]) : '0;
      end
`endif
      default: known = 1'b0;
    endcase
    unique case (func3_q[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = rd_val | operand;
      2'b11:   new_val = rd_val & ~operand;
      default: new_val = rd_val;
    endcase
    illegal  = !known || (func3_q[1:0] == 2'b00) || ((addr_q[11:10] == 2'b11) && wen);
    do_write = (state_q == S_EXEC) && wen && !illegal;
  end

`ifdef CSR_COUNTERS_EN
  // A written half replaces that half of the incremented value; the other half
  // keeps its normal increment (carry from the old low half, not the new one).
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = instret_pulse ? (minstret_q + 64'd1) : minstret_q;
    if (do_write) begin
      unique case (addr_q)
        12'hB00: mcycle_d[XLEN-1:0]   = new_val;
        12'hB02: minstret_d[XLEN-1:0] = new_val;
        12'hB80: mcycle_d[63:32]      = new_val[31:0];
        12'hB82: minstret_d[63:32]    = new_val[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      illegal_q    <= 1'b0;
      func3_q      <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      mscratch_q   <= '0;
      mtvec_q      <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            func3_q <= bus.req_func3;
            addr_q  <= bus.req_addr;
            idx_q   <= bus.req_rs1_idx;
            data_q  <= bus.req_rs1_data;
            ready_q <= 1'b0;
            state_q <= S_EXEC;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_EXEC: begin
          resp_valid_q <= 1'b1;
          rdata_q      <= illegal ? '0 : rd_val;
          illegal_q    <= illegal;
          if (do_write) begin
            unique case (addr_q)
              12'h340: mscratch_q <= new_val;
              12'h305: mtvec_q    <= {new_val[XLEN-1:2], 2'b00};
              12'h341: mepc_q     <= {new_val[XLEN-1:2], 2'b00};
              12'h342: mcause_q   <= new_val;
              default: ;
            endcase
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit -- directed scoreboard bench for csr_unit (XLEN=32).
// Stimulus pushes expected responses into a queue; a negedge monitor pops and
// compares whenever resp_valid is seen, including response latency.
module tb_csr_unit;

  logic clk = 1'b0;
  logic reset;
  logic instret_pulse;
  always #5 clk = ~clk;

  csr_unit_if #(.XLEN(32)) bus ();

  csr_unit #(
    .XLEN        (32),
    .MTVEC_RESET (32'h8000_0007)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .instret_pulse (instret_pulse),
    .bus           (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [31:0] mask;
    bit          ill;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: accepted at edge A, pushed at the following negedge,
  // response must be visible at the negedge after edge A+1.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_resp: rdata=%h illegal=%0b with no request outstanding",
                 bus.resp_rdata, bus.resp_illegal);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((bus.resp_illegal === e.ill) &&
            ((bus.resp_rdata & e.mask) === (e.rdata & e.mask)) &&
            (cyc - e.acc == 1))
          n_pass++;
        else
          $display("FAIL %s: got rdata=%h illegal=%0b latency=%0d, expected rdata=%h (mask %h) illegal=%0b latency=1",
                   e.name, bus.resp_rdata, bus.resp_illegal, cyc - e.acc, e.rdata, e.mask, e.ill);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input string name, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] idx, input logic [31:0] data,
                       input logic [31:0] exp_rd, input logic [31:0] mask,
                       input bit exp_ill, input bit expect_resp);
    bit got = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_func3    = f3;
    bus.req_addr     = addr;
    bus.req_rs1_idx  = idx;
    bus.req_rs1_data = data;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready === 1'b1) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL handshake_%s: req_ready=%0b for 20 cycles, required 1", name, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (expect_resp) begin
      exp_t e;
      e.name = name; e.rdata = exp_rd; e.mask = mask; e.ill = exp_ill; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; instret_pulse = 1'b0;
    bus.req_valid = 1'b0; bus.req_func3 = '0; bus.req_addr = '0;
    bus.req_rs1_idx = '0; bus.req_rs1_data = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.req_ready), 64'd0);
    check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset_rdata", 64'(bus.resp_rdata), 64'd0);
    check("reset_illegal", 64'(bus.resp_illegal), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.req_ready), 64'd1);

    issue("mscratch_init",   3'b010, 12'h340, 5'd0, 32'h0,         32'h0,         ALL, 1'b0, 1'b1);
    issue("swap_rw",         3'b001, 12'h340, 5'd5, 32'hDEADBEEF,  32'h0,         ALL, 1'b0, 1'b1);
    issue("swap_read",       3'b010, 12'h340, 5'd0, 32'h0,         32'hDEADBEEF,  ALL, 1'b0, 1'b1);
    issue("set_f0",          3'b001, 12'h340, 5'd1, 32'h000000F0,  32'hDEADBEEF,  ALL, 1'b0, 1'b1);
    issue("csrrsi_3",        3'b110, 12'h340, 5'd3, 32'h0000FFFF,  32'h000000F0,  ALL, 1'b0, 1'b1);
    issue("csrrc_x0",        3'b011, 12'h340, 5'd0, 32'hFFFFFFFF,  32'h000000F3,  ALL, 1'b0, 1'b1);
    issue("after_csrrc",     3'b010, 12'h340, 5'd0, 32'h0,         32'h000000F3,  ALL, 1'b0, 1'b1);
    issue("mtvec_reset",     3'b010, 12'h305, 5'd0, 32'h0,         32'h80000004,  ALL, 1'b0, 1'b1);
    issue("mtvec_write",     3'b001, 12'h305, 5'd2, 32'hFFFFFFFF,  32'h80000004,  ALL, 1'b0, 1'b1);
    issue("mtvec_masked",    3'b010, 12'h305, 5'd0, 32'h0,         32'hFFFFFFFC,  ALL, 1'b0, 1'b1);
    issue("mepc_rwi",        3'b101, 12'h341, 5'h1F, 32'h0,        32'h0,         ALL, 1'b0, 1'b1);
    issue("mepc_masked",     3'b010, 12'h341, 5'd0, 32'h0,         32'h0000001C,  ALL, 1'b0, 1'b1);
    issue("mcause_rw",       3'b001, 12'h342, 5'd7, 32'h12345678,  32'h0,         ALL, 1'b0, 1'b1);
    issue("mcause_rci",      3'b111, 12'h342, 5'd8, 32'h0,         32'h12345678,  ALL, 1'b0, 1'b1);
    issue("mcause_read",     3'b010, 12'h342, 5'd0, 32'h0,         32'h12345670,  ALL, 1'b0, 1'b1);
    issue("unknown_addr",    3'b010, 12'h123, 5'd0, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);
    issue("func3_000",       3'b000, 12'h340, 5'd4, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);
    issue("no_write_f3_000", 3'b010, 12'h340, 5'd0, 32'h0,         32'h000000F3,  ALL, 1'b0, 1'b1);
    issue("ro_rw_c00",       3'b001, 12'hC00, 5'd1, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);
    issue("ro_rsi_c00",      3'b110, 12'hC00, 5'd1, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);

`ifdef CSR_COUNTERS_EN
    // mcycle = 0x100 committed at edge A+1; read accepted at A+6 sees 0x105.
    issue("mcycle_set",      3'b001, 12'hB00, 5'd1, 32'h00000100,  32'h0,         32'h0, 1'b0, 1'b1);
    issue("ro_write_ill",    3'b001, 12'hC00, 5'd1, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);
    issue("cycle_mirror",    3'b010, 12'hC00, 5'd0, 32'h0,         32'h00000105,  ALL, 1'b0, 1'b1);
    // low = 0xFFFFFFFF at A+1, wraps at A+2 carrying into the high half.
    issue("mcycle_ffff",     3'b001, 12'hB00, 5'd1, 32'hFFFFFFFF,  32'h0,         32'h0, 1'b0, 1'b1);
    issue("mcycleh_carry",   3'b010, 12'hB80, 5'd0, 32'h0,         32'h00000001,  ALL, 1'b0, 1'b1);
    issue("mcycle_wrapped",  3'b010, 12'hB00, 5'd0, 32'h0,         32'h00000004,  ALL, 1'b0, 1'b1);
    issue("cycleh_mirror",   3'b010, 12'hC80, 5'd0, 32'h0,         32'h00000001,  ALL, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    instret_pulse = 1'b1;
    issue("minstreth_w",     3'b001, 12'hB82, 5'd1, 32'h00000055,  32'h0,         ALL, 1'b0, 1'b1);
    @(negedge clk);
    instret_pulse = 1'b0;
    issue("minstreth_kept",  3'b010, 12'hB82, 5'd0, 32'h0,         32'h00000055,  ALL, 1'b0, 1'b1);
    issue("minstret_low",    3'b010, 12'hB02, 5'd0, 32'h0,         32'h00000002,  ALL, 1'b0, 1'b1);
    issue("instret_mirror",  3'b010, 12'hC02, 5'd0, 32'h0,         32'h00000002,  ALL, 1'b0, 1'b1);
`else
    issue("no_cnt_b00",      3'b010, 12'hB00, 5'd0, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);
    issue("no_cnt_c00",      3'b010, 12'hC00, 5'd0, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);
    issue("no_cnt_b80",      3'b010, 12'hB80, 5'd0, 32'h0,         32'h0,         ALL, 1'b1, 1'b1);
`endif

    // Reset during EXEC aborts the write and the response.
    issue("abort_rw",        3'b001, 12'h340, 5'd1, 32'hAAAA5555,  32'h0,         ALL, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready_in_reset", 64'(bus.req_ready), 64'd0);
    check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 64'(bus.req_ready), 64'd1);
    issue("abort_no_write",  3'b010, 12'h340, 5'd0, 32'h0,         32'h0,         ALL, 1'b0, 1'b1);
    issue("mtvec_rereset",   3'b010, 12'h305, 5'd0, 32'h0,         32'h80000004,  ALL, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
